conv_sched: RTL and testbench

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_sched_outbuf.sv | 64 ++++++
 rtl/conv_sched.sv | 209 ++++++++++++++++++++
 tb/tb_conv_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg -- shared types and constants for the convolution scheduler.
//
// Contents:
//   state_t     scheduler FSM state encoding
//   DW_DEF      default activation width
//   ACCW_DEF    default convolver result width
//   opf_calc()  outputs per filter for an NxN map, KxK kernel, stride S
//   clog2_min1() ceil(log2(v)) clamped to at least 1 bit for port widths

package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CRST,
      STREAM,
      DRAIN,
      NEXT
   } state_t;

   localparam int DW_DEF   = 16;
   localparam int ACCW_DEF = 32;

   function automatic int opf_calc(input int n, input int k, input int s);
      int side;
      side = (n - k) / s + 1;
      return side * side;
   endfunction

   // A zero-width bus is illegal, so single-value ranges still get one bit
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/conv_sched_outbuf.sv
// conv_sched_outbuf -- one-entry valid/ready output register for the
// scheduler's result stream.
//
// Ports:
//   clk, global_rst          clock, synchronous active-high reset
//   capture                  load cap_* this cycle (only asserted when space=1)
//   cap_data/filt/idx        result, filter index and position to store
//   out_ready                downstream accept
//   out_valid/data/filt/idx  registered result stream
//   space                    register empty, or being drained this cycle
//
// Build option: CONV_SCHED_RELU_EN clamps negative results to zero at capture.

module conv_sched_outbuf #(
   parameter int ACCW = 32,
   parameter int FW   = 1,
   parameter int IW   = 2
) (
   input  logic            clk,
   input  logic            global_rst,
   input  logic            capture,
   input  logic [ACCW-1:0] cap_data,
   input  logic [FW-1:0]   cap_filt,
   input  logic [IW-1:0]   cap_idx,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [ACCW-1:0] out_data,
   output logic [FW-1:0]   out_filt,
   output logic [IW-1:0]   out_idx,
   output logic            space
);

   logic            accept;
   logic [ACCW-1:0] load_data;

   assign accept = out_valid && out_ready;
   assign space  = !out_valid || accept;

`ifdef CONV_SCHED_RELU_EN
   assign load_data = cap_data[ACCW-1] ? '0 : cap_data;
`else
   assign load_data = cap_data;
`endif

   // Capture takes priority over accept so a same-cycle drain and refill
   // keeps out_valid high; payload only changes on capture, so it holds
   // steady while the consumer stalls.
   always_ff @(posedge clk) begin
      if (global_rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_filt  <= '0;
         out_idx   <= '0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_filt  <= cap_filt;
         out_idx   <= cap_idx;
      end else if (accept) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/conv_sched.sv
// conv_sched -- layer-pass scheduler feeding a streaming KxK convolver.
// For each of NUM_FILT weight banks it resets the convolver, streams the
// NxN activation map from memory, and forwards the OPF results through a
// valid/ready output register.
//
// Ports:
//   clk, global_rst             clock, synchronous active-high reset
//   start / busy / done         pass request, pass in progress, completion pulse
//   act_rd_en, act_addr         activation memory read (data one cycle later)
//   act_data                    activation read data
//   conv_ce, conv_rst           convolver clock enable and reset
//   conv_act, w_sel             activation to convolver, weight-bank select
//   conv_op, valid_conv         convolver result and its strobe
//   end_conv                    convolver end-of-map strobe
//   out_valid/ready/data/filt/idx  result stream
//   err                         sticky protocol-error flag
//
// Build option: CONV_SCHED_RELU_EN (handled in conv_sched_outbuf) clamps
// negative results to zero.

module conv_sched
   import conv_pkg::*;
#(
   parameter int N        = 6,
   parameter int K        = 5,
   parameter int S        = 1,
   parameter int NUM_FILT = 4,
   parameter int DW       = DW_DEF,
   parameter int ACCW     = ACCW_DEF
) (
   input  logic                                    clk,
   input  logic                                    global_rst,
   input  logic                                    start,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    act_rd_en,
   output logic [clog2_min1(N*N)-1:0]              act_addr,
   input  logic [DW-1:0]                           act_data,
   output logic                                    conv_ce,
   output logic                                    conv_rst,
   output logic [DW-1:0]                           conv_act,
   output logic [clog2_min1(NUM_FILT)-1:0]         w_sel,
   input  logic [ACCW-1:0]                         conv_op,
   input  logic                                    valid_conv,
   input  logic                                    end_conv,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [ACCW-1:0]                         out_data,
   output logic [clog2_min1(NUM_FILT)-1:0]         out_filt,
   output logic [clog2_min1(opf_calc(N,K,S))-1:0]  out_idx,
   output logic                                    err
);

   localparam int NN  = N * N;
   localparam int OPF = opf_calc(N, K, S);
   localparam int AW  = clog2_min1(NN);
   localparam int CW  = $clog2(NN + 1);
   localparam int FW  = clog2_min1(NUM_FILT);
   localparam int IW  = clog2_min1(OPF);
   localparam int RW  = $clog2(OPF + 1);

   state_t          state;
   state_t          state_nxt;
   logic [FW-1:0]   f;
   logic [CW-1:0]   rd_cnt;
   logic [CW-1:0]   cons_cnt;
   logic [RW-1:0]   res_cnt;
   logic            rd_pend;
   logic            act_valid;
   logic [DW-1:0]   act_q;
   logic            space;
   logic            capture;

   assign act_addr = rd_cnt[AW-1:0];
   assign conv_act = act_q;
   assign w_sel    = f;
   assign conv_ce  = act_valid && space;
   // A result arriving after the map is already complete is flagged, not stored
   assign capture  = conv_ce && valid_conv && (res_cnt < RW'(OPF));

   // State register
   always_ff @(posedge clk) begin
      if (global_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control decode. A read is issued only when nothing is
   // in flight and the activation register is free (or emptying), so the
   // returning word always has somewhere to land even if the convolver stalls.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = 1'b0;
      conv_rst  = global_rst;
      act_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = CRST;
            end
         end
         CRST: begin
            conv_rst  = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            act_rd_en = (rd_cnt < CW'(NN)) && !rd_pend && (!act_valid || conv_ce);
            if (cons_cnt == CW'(NN)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if ((res_cnt == RW'(OPF)) && !out_valid) begin
               state_nxt = NEXT;
            end
         end
         NEXT: begin
            if (f < FW'(NUM_FILT - 1)) begin
               state_nxt = CRST;
            end else begin
               done      = 1'b1;
               busy      = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Filter index, read/consume/result counters and the activation register.
   // Counters restart in CRST so each filter sees the map from address 0.
   always_ff @(posedge clk) begin
      if (global_rst) begin
         f         <= '0;
         rd_cnt    <= '0;
         cons_cnt  <= '0;
         res_cnt   <= '0;
         rd_pend   <= 1'b0;
         act_valid <= 1'b0;
         act_q     <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            f <= '0;
         end else if ((state == NEXT) && (f < FW'(NUM_FILT - 1))) begin
            f <= f + 1'b1;
         end

         if (state == CRST) begin
            rd_cnt    <= '0;
            cons_cnt  <= '0;
            res_cnt   <= '0;
            rd_pend   <= 1'b0;
            act_valid <= 1'b0;
         end else begin
            rd_pend <= act_rd_en;
            if (act_rd_en) begin
               rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_pend) begin
               act_q     <= act_data;
               act_valid <= 1'b1;
            end else if (conv_ce) begin
               act_valid <= 1'b0;
            end
            if (conv_ce) begin
               cons_cnt <= cons_cnt + 1'b1;
            end
            if (capture) begin
               res_cnt <= res_cnt + 1'b1;
            end
         end
      end
   end

   // Sticky error: map ended early, or a result beyond the expected count
   always_ff @(posedge clk) begin
      if (global_rst) begin
         err <= 1'b0;
      end else if ((end_conv && (res_cnt < RW'(OPF - 1))) ||
                   (valid_conv && (res_cnt == RW'(OPF)))) begin
         err <= 1'b1;
      end
   end

   conv_sched_outbuf #(
      .ACCW (ACCW),
      .FW   (FW),
      .IW   (IW)
   ) u_outbuf (
      .clk        (clk),
      .global_rst (global_rst),
      .capture    (capture),
      .cap_data   (conv_op),
      .cap_filt   (f),
      .cap_idx    (res_cnt[IW-1:0]),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_filt   (out_filt),
      .out_idx    (out_idx),
      .space      (space)
   );

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched -- scoreboard bench for conv_sched with N=6, K=5, S=1,
// NUM_FILT=2. Activation memory holds mem[i]=i; a behavioural stub
// convolver multiplies each 5x5 window sum by a per-bank scalar weight.
// Window sums for mem[i]=i are 350, 375, 500, 525 for positions 0..3.
// Honours CONV_SCHED_RELU_EN when computing expected results.

module tb_conv_sched;

   localparam int N        = 6;
   localparam int K        = 5;
   localparam int S        = 1;
   localparam int NUM_FILT = 2;
   localparam int DW       = 16;
   localparam int ACCW     = 32;
   localparam int OPF      = 4;

   logic            clk = 1'b0;
   logic            global_rst;
   logic            start;
   logic            busy;
   logic            done;
   logic            act_rd_en;
   logic [5:0]      act_addr;
   logic [DW-1:0]   act_data;
   logic            conv_ce;
   logic            conv_rst;
   logic [DW-1:0]   conv_act;
   logic [0:0]      w_sel;
   logic [ACCW-1:0] conv_op;
   logic            valid_conv;
   logic            end_conv;
   logic            out_valid;
   logic            out_ready;
   logic [ACCW-1:0] out_data;
   logic [0:0]      out_filt;
   logic [1:0]      out_idx;
   logic            err;

   typedef struct {
      logic [ACCW-1:0] data;
      logic [0:0]      filt;
      logic [1:0]      idx;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;
   int wval [0:1];
   int base [0:3];
   bit early_end = 1'b0;

   logic [DW-1:0]   hist [0:N*N-1];
   int              scnt;
   int              sres;

   bit              stall_prev = 1'b0;
   logic [ACCW-1:0] held_data;
   logic [1:0]      held_idx;

   always #5 clk = ~clk;

   conv_sched #(
      .N        (N),
      .K        (K),
      .S        (S),
      .NUM_FILT (NUM_FILT),
      .DW       (DW),
      .ACCW     (ACCW)
   ) dut (
      .clk        (clk),
      .global_rst (global_rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .act_rd_en  (act_rd_en),
      .act_addr   (act_addr),
      .act_data   (act_data),
      .conv_ce    (conv_ce),
      .conv_rst   (conv_rst),
      .conv_act   (conv_act),
      .w_sel      (w_sel),
      .conv_op    (conv_op),
      .valid_conv (valid_conv),
      .end_conv   (end_conv),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_filt   (out_filt),
      .out_idx    (out_idx),
      .err        (err)
   );

   // Activation memory: mem[i]=i, junk on the bus when not read
   always @(posedge clk) begin
      act_data <= act_rd_en ? DW'(act_addr) : 16'hBEEF;
   end

   // Stub convolver: history of consumed activations
   always @(posedge clk) begin
      if (conv_rst) begin
         scnt <= 0;
         sres <= 0;
      end else if (conv_ce) begin
         if (scnt < N*N) hist[scnt] <= conv_act;
         scnt <= scnt + 1;
         if (valid_conv) sres <= sres + 1;
      end
   end

   // Stub convolver: a result appears with the activation completing a window
   always_comb begin
      int r;
      int c;
      int idx;
      int sum;
      valid_conv = 1'b0;
      end_conv   = 1'b0;
      conv_op    = '0;
      sum        = 0;
      idx        = 0;
      r          = scnt / N;
      c          = scnt % N;
      if (conv_ce && (r >= K-1) && (r < N) && (c >= K-1)) begin
         valid_conv = 1'b1;
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
               idx = (r-K+1+i)*N + (c-K+1+j);
               if (idx == scnt) sum = sum + int'(conv_act);
               else             sum = sum + int'(hist[idx]);
            end
         end
         conv_op  = ACCW'(wval[w_sel] * sum);
         end_conv = early_end ? (sres == 2) : (sres == OPF-1);
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted result, checks hold
   // behaviour and convolver back-pressure while the consumer stalls
   always @(negedge clk) begin
      if (global_rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_data", 64'(out_data), 64'(held_data));
            checkOutput("hold_idx", 64'(out_idx), 64'(held_idx));
         end
         if (out_valid && !out_ready) begin
            checkOutput("ce_blocked", 64'(conv_ce), 64'd0);
         end
         stall_prev = out_valid && !out_ready;
         held_data  = out_data;
         held_idx   = out_idx;
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_result", 64'(sb_q.size()), 64'd1);
            end else begin
               mon_e = sb_q.pop_front();
               checkOutput("out_data", 64'(out_data), 64'(mon_e.data));
               checkOutput("out_filt", 64'(out_filt), 64'(mon_e.filt));
               checkOutput("out_idx", 64'(out_idx), 64'(mon_e.idx));
            end
         end
      end
   end

   task automatic pushExpected();
      exp_t e;
      int v;
      for (int fi = 0; fi < NUM_FILT; fi++) begin
         for (int o = 0; o < OPF; o++) begin
            v = wval[fi] * base[o];
`ifdef CONV_SCHED_RELU_EN
            if (v < 0) v = 0;
`endif
            e.data = ACCW'(v);
            e.filt = 1'(fi);
            e.idx  = 2'(o);
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_act_rd_en", 64'(act_rd_en), 64'd0);
      checkOutput("rst_act_addr", 64'(act_addr), 64'd0);
      checkOutput("rst_conv_ce", 64'(conv_ce), 64'd0);
      checkOutput("rst_conv_rst", 64'(conv_rst), 64'd1);
      checkOutput("rst_w_sel", 64'(w_sel), 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_data", 64'(out_data), 64'd0);
      checkOutput("rst_out_filt", 64'(out_filt), 64'd0);
      checkOutput("rst_out_idx", 64'(out_idx), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
   endtask

   // One full pass: pulse start, optionally stall the consumer after the
   // first result and/or re-pulse start mid-stream, then count done pulses
   task automatic applyStimulus(input int stall_cycles, input bit extra_start);
      int  stall_left;
      bit  stall_started;
      int  dones;
      int  tail;
      stall_left    = stall_cycles;
      stall_started = 1'b0;
      dones         = 0;
      tail          = 0;
      pushExpected();
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; (cyc < 3000) && (tail < 8); cyc++) begin
         @(posedge clk); #1;
         start = extra_start && (cyc == 30);
         if (stall_left > 0) begin
            if (!stall_started && out_valid) begin
               stall_started = 1'b1;
               out_ready     = 1'b0;
            end else if (stall_started) begin
               stall_left--;
               if (stall_left == 0) out_ready = 1'b1;
            end
         end
         if (done) dones++;
         if (dones > 0) tail++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      checkOutput("done_pulses", 64'(dones), 64'd1);
      checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
      checkOutput("busy_after", 64'(busy), 64'd0);
      checkOutput("err_after", 64'(err), 64'(early_end));
   endtask

   initial begin
      base[0] = 350;
      base[1] = 375;
      base[2] = 500;
      base[3] = 525;
      wval[0] = 1;
      wval[1] = 2;
      global_rst = 1'b1;
      start      = 1'b0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetState();
      global_rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle_conv_rst", 64'(conv_rst), 64'd0);
      checkOutput("idle_busy", 64'(busy), 64'd0);

      $display("[TB] basic pass, two filters");
      applyStimulus(0, 1'b0);

      $display("[TB] consumer stall of 10 cycles");
      applyStimulus(10, 1'b0);

      $display("[TB] start pulsed mid-stream");
      applyStimulus(0, 1'b1);

      $display("[TB] reset during filter 1 stream");
      pushExpected();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         bit found;
         found = 1'b0;
         for (int cyc = 0; (cyc < 1000) && !found; cyc++) begin
            @(posedge clk); #1;
            if ((w_sel == 1'b1) && act_rd_en) found = 1'b1;
         end
         checkOutput("reach_filter1", 64'(found), 64'd1);
      end
      repeat (5) @(posedge clk);
      #1;
      global_rst = 1'b1;
      @(posedge clk); #1;
      checkResetState();
      global_rst = 1'b0;
      sb_q.delete();
      applyStimulus(0, 1'b0);

      $display("[TB] negative weights");
      wval[0] = -1;
      wval[1] = -1;
      applyStimulus(0, 1'b0);

      $display("[TB] early end_conv from convolver");
      wval[0] = 1;
      wval[1] = 2;
      early_end = 1'b1;
      applyStimulus(0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("err_sticky", 64'(err), 64'd1);
      early_end  = 1'b0;
      global_rst = 1'b1;
      @(posedge clk); #1;
      global_rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("err_cleared", 64'(err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
